// File: rtl/avr_pkg.sv
// Shared widths and types for the fetch front end, plus a saturating
// increment helper for the optional performance counters.
package avr_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 16;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch unit, program memory, execute (redirect)
// and the downstream decode stage.
interface instr_fetch_if;
  import avr_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instruction;
  logic [PC_W-1:0]    pc;

  // Decode handshake: a transfer happens on a rising edge where
  // instr_valid && instr_ready; while instr_valid is high and the transfer
  // has not happened, instruction/pc are held stable. imem_rdata answers
  // an imem_req exactly one cycle later with no back-pressure.
  modport master (
    output imem_req, imem_addr, instr_valid, instruction, pc,
    input  imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, pc,
    output imem_rdata, redirect, redirect_pc, instr_ready
  );

endinterface

// File: rtl/instr_fetch_sync_fifo.sv
// Synchronous FIFO of a parameterized element type; clear has priority over
// push and pop, and a push into a full FIFO is accepted when a pop coincides.
module sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  input  logic                   clear,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; readers qualify it with empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction prefetch unit: credit-limited fetch into a small FIFO with
// redirect flush. Optional perf counters under macro FETCH_PERF_CNT_EN.
module instr_fetch
  import avr_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_if.master       bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    fetch_cnt,
  output logic [CNT_W-1:0]    flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [CW:0]     credit;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            issue;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  // Credit counts buffered plus in-flight words; the slot freed by a pop
  // this cycle can be reused immediately, which sustains one per cycle.
  assign pop    = !fifo_empty && bus.instr_ready;
  assign credit = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue  = reset && !bus.redirect && !(fifo_full && !pop)
                  && (credit < (CW+1)'(DEPTH));

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 1'b1;
      end
    end
  end

  assign push_entry = '{pc: inflight_pc, instr: bus.imem_rdata};

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (inflight),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (bus.redirect),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign bus.instr_valid = !fifo_empty;
  assign bus.instruction = fifo_empty ? '0 : head.instr;
  assign bus.pc          = fifo_empty ? '0 : head.pc;

`ifdef FETCH_PERF_CNT_EN
  // A redirect swallows any pop offered in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else if (bus.redirect) begin
      flush_cnt <= sat_inc(flush_cnt);
    end else if (pop) begin
      fetch_cnt <= sat_inc(fetch_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch (DEPTH=4, RESET_PC=8'h00);
// counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_instr_fetch;
  import avr_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  instr_fetch #(
    .DEPTH    (4),
    .RESET_PC (8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt (fetch_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  // Program memory: word at address a is {a ^ 8'h5A, a}, returned next cycle.
  function automatic logic [15:0] pat(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= pat(bus.imem_addr);
  end

  // ---------------- scoreboard ----------------
  int n_cmp;
  int n_bad;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the edge; outputs are sampled 2 after.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_head(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
      check({tag, "_pc"}, 32'(bus.pc), 32'(e));
      check({tag, "_instr"}, 32'(bus.instruction), 32'(pat(e)));
    end
  endtask

  task automatic run_stream(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check_head(tag);
    end
  endtask

  task automatic push_seq(input logic [7:0] start, input int n);
    logic [7:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 8'd1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 8'h00;

    // Held in reset
    repeat (2) step();
    check("rst_req",   32'(bus.imem_req),    32'd0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", 32'(bus.instruction), 32'h0000);
    check("rst_pc",    32'(bus.pc),          32'h00);
    check("rst_addr",  32'(bus.imem_addr),   32'h00);
`ifdef FETCH_PERF_CNT_EN
    check("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
`endif

    // Release: request in cycle 0, first instruction in cycle 2
    next_cycle(); reset = 1'b1; settle();
    check("c0_req",   32'(bus.imem_req),    32'd1);
    check("c0_addr",  32'(bus.imem_addr),   32'h00);
    check("c0_valid", 32'(bus.instr_valid), 32'd0);
    step();
    check("c1_valid", 32'(bus.instr_valid), 32'd0);
    check("c1_addr",  32'(bus.imem_addr),   32'h01);
    push_seq(8'h00, 8);
    run_stream("stream", 8);

    // Stall for 10 cycles with pc 08 at the head
    next_cycle(); bus.instr_ready = 1'b0; settle();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      check("stall_valid", 32'(bus.instr_valid), 32'd1);
      check("stall_pc",    32'(bus.pc),          32'h08);
      check("stall_instr", 32'(bus.instruction), 32'(pat(8'h08)));
      check("stall_req",   32'(bus.imem_req),    32'(k < 2));
    end
    next_cycle(); bus.instr_ready = 1'b1; settle();
    push_seq(8'h08, 8);
    check_head("unstall");
    run_stream("unstall", 7);

    // Redirect to 40 with three entries buffered and one in flight
    next_cycle(); bus.redirect = 1'b1; bus.redirect_pc = 8'h40; settle();
    check("redir_req", 32'(bus.imem_req), 32'd0);
    next_cycle(); bus.redirect = 1'b0; settle();
    check("redir_r1_valid", 32'(bus.instr_valid), 32'd0);
    check("redir_r1_req",   32'(bus.imem_req),    32'd1);
    check("redir_r1_addr",  32'(bus.imem_addr),   32'h40);
    step();
    check("redir_r2_valid", 32'(bus.instr_valid), 32'd0);
    push_seq(8'h40, 4);
    run_stream("redir", 4);

    // Address wrap FE -> FF -> 00 -> 01
    next_cycle(); bus.redirect = 1'b1; bus.redirect_pc = 8'hFE; settle();
    next_cycle(); bus.redirect = 1'b0; settle();
    check("wrap_r1_addr",  32'(bus.imem_addr),   32'hFE);
    check("wrap_r1_valid", 32'(bus.instr_valid), 32'd0);
    step();
    check("wrap_r2_addr",  32'(bus.imem_addr),   32'hFF);
    push_seq(8'hFE, 4);
    run_stream("wrap", 4);

    // One-cycle reset mid-stream
    next_cycle(); reset = 1'b0; settle();
    check("mid_rst_req",   32'(bus.imem_req),    32'd0);
    check("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    check("mid_rst_pc",    32'(bus.pc),          32'h00);
    check("mid_rst_instr", 32'(bus.instruction), 32'h0000);
    next_cycle(); reset = 1'b1; settle();
    check("rerun_c0_req",  32'(bus.imem_req),    32'd1);
    check("rerun_c0_addr", 32'(bus.imem_addr),   32'h00);
    check("rerun_c0_valid", 32'(bus.instr_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rerun_fetch_cnt", 32'(fetch_cnt), 32'd0);
    check("rerun_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    step();
    check("rerun_c1_valid", 32'(bus.instr_valid), 32'd0);
    push_seq(8'h00, 4);
    run_stream("rerun", 4);

    // Fill to DEPTH, then redirect together with a valid pop
    next_cycle(); bus.instr_ready = 1'b0; settle();
    repeat (3) step();
    check("full_req",   32'(bus.imem_req),    32'd0);
    check("full_valid", 32'(bus.instr_valid), 32'd1);
    check("full_pc",    32'(bus.pc),          32'h04);
    next_cycle();
    bus.instr_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 8'h80;
    settle();
    check("fullredir_req", 32'(bus.imem_req), 32'd0);
    next_cycle(); bus.redirect = 1'b0; settle();
    check("fullredir_valid", 32'(bus.instr_valid), 32'd0);
    check("fullredir_addr",  32'(bus.imem_addr),   32'h80);
`ifdef FETCH_PERF_CNT_EN
    check("fullredir_fetch_cnt", 32'(fetch_cnt), 32'd4);
    check("fullredir_flush_cnt", 32'(flush_cnt), 32'd1);
`endif
    step();
    check("fullredir_r2_valid", 32'(bus.instr_valid), 32'd0);
    push_seq(8'h80, 2);
    run_stream("fullredir", 2);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
